pipeline_ctrl: RTL



---
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central hazard/stall controller for the 5-stage 16-bit pipeline.
//   - Detects load-use hazards between the ID and EX stages.
//   - Flushes IF/ID and ID/EX on a taken branch resolved in EX.
//   - Sequences fixed data-memory wait states (MEM_WAIT) followed by an
//     open-ended wait for mem_ready_i.
//   - Counts stalled cycles in a saturating performance counter.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            asynchronous active-low reset
//   id_rs1_i/rs2_i   source registers of the ID instruction
//   id_useRs1_i/2_i  ID instruction actually reads rs1/rs2
//   ex_memRead_i     EX instruction is a load
//   ex_reg3_i        destination register of the EX instruction
//   ex_branchTaken_i EX resolved a taken branch/jump
//   mem_req_i        MEM stage holds a load or store
//   mem_ready_i      data memory ready/ack
//   stall_o          stall code for PC and pipeline registers
//   flush_o          flush of IF/ID and ID/EX
//   mem_done_o       one-cycle pulse when a memory access completes
//   stall_cnt_o      saturating count of cycles with stall_o != 0
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int REG_W    = 3,
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_useRs1_i,
    input  logic             id_useRs2_i,
    input  logic             ex_memRead_i,
    input  logic [REG_W-1:0] ex_reg3_i,
    input  logic             ex_branchTaken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             mem_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_LOADUSE = 6'b001011;
    localparam logic [5:0] STALL_MEMWAIT = 6'b011111;

    // A zero-wait configuration still needs a legal (1-bit) counter.
    localparam int WCNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT =
        (MEM_WAIT > 0) ? WCNT_W'(MEM_WAIT - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        MWAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic mem_stall;   // memory wait is holding the pipeline this cycle
    logic mem_exit;    // access completes this cycle
    logic load_use;

    assign load_use = ex_memRead_i &
                      ((id_useRs1_i & (id_rs1_i == ex_reg3_i)) |
                       (id_useRs2_i & (id_rs2_i == ex_reg3_i)));

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if (MEM_WAIT > 0) begin
                        state_d = MWAIT;
                        wcnt_d  = WCNT_INIT;
                    end else if (!mem_ready_i) begin
                        // Zero-wait memory that is not ready yet: park in
                        // MWAIT with the counter already expired.
                        state_d = MWAIT;
                        wcnt_d  = '0;
                    end
                end
            end
            MWAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase

        // Stall counter saturates at all-ones.
        cnt_d = cnt_q;
        if ((stall_o != STALL_NONE) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_stall  = 1'b0;
        mem_exit   = 1'b0;
        stall_o    = STALL_NONE;
        flush_o    = 1'b0;
        mem_done_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    if ((MEM_WAIT == 0) && mem_ready_i) begin
                        mem_exit = 1'b1;
                    end else begin
                        mem_stall = 1'b1;
                    end
                end
            end
            MWAIT: begin
                if ((wcnt_q == '0) && mem_ready_i) begin
                    mem_exit = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase

        // Outputs are silent while reset is held. A taken branch outranks
        // load-use because the ID instruction is discarded anyway; while the
        // memory stall is active EX is frozen, so the branch is delayed until
        // the wait ends rather than lost.
        if (rst_i) begin
            mem_done_o = mem_exit;
            if (mem_stall) begin
                stall_o = STALL_MEMWAIT;
            end else if (ex_branchTaken_i) begin
                flush_o = 1'b1;
            end else if (load_use) begin
                stall_o = STALL_LOADUSE;
            end
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule
